// File: rtl/dlx_decode_if.sv
// dlx_decode_if: fetch/execute-facing bus of the DLX ID stage.
//   master modport: the pipeline around decode (drives fetch and flush inputs,
//                   receives the register-file read addresses, stall and ID/EX).
//   slave modport : the decode stage itself.
// Signals:
//   if_valid, if_instr[31:0], if_pc[PC_W-1:0]  fetched instruction
//   ex_flush                                  taken branch/jump in EX
//   Rs1, Rs2 [4:0]                            register file read addresses
//   stall                                     fetch must hold this cycle
//   ex_valid, ex_pc, ex_op, ex_func, ex_rd, ex_imm,
//   ex_is_load, ex_is_store, ex_reg_we        ID/EX pipeline register
interface dlx_decode_if #(parameter int PC_W = 32);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [PC_W-1:0] if_pc;
  logic            ex_flush;
  logic [4:0]      Rs1;
  logic [4:0]      Rs2;
  logic            stall;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic [5:0]      ex_op;
  logic [5:0]      ex_func;
  logic [4:0]      ex_rd;
  logic [31:0]     ex_imm;
  logic            ex_is_load;
  logic            ex_is_store;
  logic            ex_reg_we;

  modport master (
    output if_valid, if_instr, if_pc, ex_flush,
    input  Rs1, Rs2, stall, ex_valid, ex_pc, ex_op, ex_func, ex_rd, ex_imm,
           ex_is_load, ex_is_store, ex_reg_we
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_flush,
    output Rs1, Rs2, stall, ex_valid, ex_pc, ex_op, ex_func, ex_rd, ex_imm,
           ex_is_load, ex_is_store, ex_reg_we
  );
endinterface

// File: rtl/dlx_decode.sv
// dlx_decode: DLX instruction decode stage and ID/EX pipeline register.
//   Splits the fetched word into fields, drives the register-file read
//   addresses combinationally, detects load-use hazards (one-cycle stall with
//   a bubble) and kills the incoming instruction on an EX flush.
// Ports:
//   clk        single clock, all state on posedge
//   reset      synchronous, active-high
//   bus        dlx_decode_if.slave (fetch inputs, Rs1/Rs2, stall, ID/EX outputs)
//   perf_instr instructions issued into ID/EX        (DECODE_PERF_EN only)
//   perf_stall load-use stall cycles                  (DECODE_PERF_EN only)
// Optional feature macro: DECODE_PERF_EN (performance counters). When it is
// not defined both counter ports are tied to zero and no counter flops exist.
module dlx_decode #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  dlx_decode_if.slave      bus,
  output logic [CNT_W-1:0] perf_instr,
  output logic [CNT_W-1:0] perf_stall
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LHI   = 6'h0F;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [31:0] instr_s;
  logic [5:0]  op_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [4:0]  rd_s;
  logic [5:0]  func_s;
  logic [31:0] imm_s;
  logic        use1_s;
  logic        use2_s;
  logic        is_load_s;
  logic        is_store_s;
  logic        we_s;
  logic        hz_s;
  logic        stall_s;

  logic            ex_valid_r;
  logic [PC_W-1:0] ex_pc_r;
  logic [5:0]      ex_op_r;
  logic [5:0]      ex_func_r;
  logic [4:0]      ex_rd_r;
  logic [31:0]     ex_imm_r;
  logic            ex_is_load_r;
  logic            ex_is_store_r;
  logic            ex_reg_we_r;

  assign instr_s = bus.if_instr;
  assign op_s    = instr_s[31:26];
  assign rs1_s   = instr_s[25:21];
  assign rs2_s   = instr_s[20:16];

  // Destination, source usage and class decode; anything not listed is I-type ALU.
  always_comb begin
    rd_s       = instr_s[20:16];
    func_s     = 6'h00;
    use1_s     = 1'b1;
    use2_s     = 1'b0;
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        rd_s   = instr_s[15:11];
        func_s = instr_s[5:0];
        use2_s = 1'b1;
      end
      OP_J: begin
        rd_s   = 5'd0;
        use1_s = 1'b0;
      end
      OP_JAL: begin
        rd_s   = 5'd31;
        use1_s = 1'b0;
      end
      OP_BEQZ, OP_BNEZ, OP_JR: begin
        rd_s = 5'd0;
      end
      OP_JALR: begin
        rd_s = 5'd31;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        is_load_s = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        rd_s       = 5'd0;
        use2_s     = 1'b1;
        is_store_s = 1'b1;
      end
      default: begin
        rd_s = instr_s[20:16];
      end
    endcase
    // Links always write r31; everything else writes only a non-zero rd.
    if ((op_s == OP_JAL) || (op_s == OP_JALR)) begin
      we_s = 1'b1;
    end else begin
      we_s = (rd_s != 5'd0);
    end
  end

  // Immediate extension by opcode class.
  always_comb begin
    case (op_s)
      OP_ANDI, OP_ORI, OP_XORI: imm_s = {16'h0000, instr_s[15:0]};
      OP_LHI:                   imm_s = {instr_s[15:0], 16'h0000};
      OP_J, OP_JAL:             imm_s = {{6{instr_s[25]}}, instr_s[25:0]};
      default:                  imm_s = {{16{instr_s[15]}}, instr_s[15:0]};
    endcase
  end

  // Load-use hazard: only sources the instruction actually reads count, and r0 never does.
  always_comb begin
    hz_s = bus.if_valid & ex_valid_r & ex_is_load_r & (ex_rd_r != 5'd0) &
           ((use1_s & (ex_rd_r == rs1_s)) | (use2_s & (ex_rd_r == rs2_s)));
    stall_s = hz_s & ~bus.ex_flush;
  end

  // ID/EX register: reset/flush/stall load a bubble, otherwise the decoded word.
  always_ff @(posedge clk) begin
    if (reset || bus.ex_flush || stall_s) begin
      ex_valid_r    <= 1'b0;
      ex_pc_r       <= '0;
      ex_op_r       <= 6'h00;
      ex_func_r     <= 6'h00;
      ex_rd_r       <= 5'd0;
      ex_imm_r      <= 32'h0000_0000;
      ex_is_load_r  <= 1'b0;
      ex_is_store_r <= 1'b0;
      ex_reg_we_r   <= 1'b0;
    end else begin
      ex_valid_r    <= bus.if_valid;
      ex_pc_r       <= bus.if_pc;
      ex_op_r       <= op_s;
      ex_func_r     <= func_s;
      ex_rd_r       <= rd_s;
      ex_imm_r      <= imm_s;
      ex_is_load_r  <= is_load_s;
      ex_is_store_r <= is_store_s;
      // An invalid slot must never write the register file.
      ex_reg_we_r   <= we_s & bus.if_valid;
    end
  end

  assign bus.Rs1         = rs1_s;
  assign bus.Rs2         = rs2_s;
  assign bus.stall       = stall_s;
  assign bus.ex_valid    = ex_valid_r;
  assign bus.ex_pc       = ex_pc_r;
  assign bus.ex_op       = ex_op_r;
  assign bus.ex_func     = ex_func_r;
  assign bus.ex_rd       = ex_rd_r;
  assign bus.ex_imm      = ex_imm_r;
  assign bus.ex_is_load  = ex_is_load_r;
  assign bus.ex_is_store = ex_is_store_r;
  assign bus.ex_reg_we   = ex_reg_we_r;

`ifdef DECODE_PERF_EN
  logic [CNT_W-1:0] perf_instr_r;
  logic [CNT_W-1:0] perf_stall_r;
  logic             issue_s;

  assign issue_s = bus.if_valid & ~bus.ex_flush & ~stall_s;

  // Issue and stall counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_instr_r <= '0;
      perf_stall_r <= '0;
    end else begin
      if (issue_s) begin
        perf_instr_r <= perf_instr_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        perf_instr_r <= perf_instr_r;
      end
      if (stall_s) begin
        perf_stall_r <= perf_stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        perf_stall_r <= perf_stall_r;
      end
    end
  end

  assign perf_instr = perf_instr_r;
  assign perf_stall = perf_stall_r;
`else
  assign perf_instr = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_dlx_decode.sv
// tb_dlx_decode: table-driven, directed and randomized checks of dlx_decode
// against an instruction-level reference model.
module tb_dlx_decode;

  logic        clk;
  logic        reset;
  logic [31:0] perf_instr;
  logic [31:0] perf_stall;

  dlx_decode_if #(.PC_W(32)) bus ();

  dlx_decode #(.PC_W(32), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .perf_instr (perf_instr),
    .perf_stall (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ld;
    logic        st;
    logic        we;
  } ex_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [5:0]  func;
    logic [31:0] imm;
    logic        we;
    logic        ld;
    logic        st;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  ex_t         m;
  logic [31:0] m_pi;
  logic [31:0] m_ps;
  logic        m_stall_last;
  logic        stall_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode written straight from the instruction-set rules.
  function automatic ex_t decode_ref(input logic [31:0] ins, input logic [31:0] pc, input logic v);
    ex_t r;
    logic [5:0] op;
    op = ins[31:26];
    r.valid = v;
    r.pc    = pc;
    r.op    = op;
    r.ld    = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    r.st    = op inside {6'h28, 6'h29, 6'h2B};
    r.func  = (op == 6'h00) ? ins[5:0] : 6'h00;
    if (op == 6'h00)                                   r.rd = ins[15:11];
    else if (op inside {6'h03, 6'h13})                 r.rd = 5'd31;
    else if (r.st || op inside {6'h02, 6'h04, 6'h05, 6'h12}) r.rd = 5'd0;
    else                                               r.rd = ins[20:16];
    r.we = ((op inside {6'h03, 6'h13}) || (r.rd != 5'd0)) && v;
    if (op inside {6'h0C, 6'h0D, 6'h0E})  r.imm = 32'(ins[15:0]);
    else if (op == 6'h0F)                 r.imm = 32'(ins[15:0]) * 32'd65536;
    else if (op inside {6'h02, 6'h03})    r.imm = 32'($signed(ins[25:0]));
    else                                  r.imm = 32'($signed(ins[15:0]));
    return r;
  endfunction

  function automatic logic ref_hazard(input logic [31:0] ins, input logic v);
    logic [5:0] op;
    logic u1, u2;
    op = ins[31:26];
    u1 = !(op inside {6'h02, 6'h03});
    u2 = (op == 6'h00) || (op inside {6'h28, 6'h29, 6'h2B});
    return v && m.valid && m.ld && (m.rd != 5'd0) &&
           ((u1 && m.rd == ins[25:21]) || (u2 && m.rd == ins[20:16]));
  endfunction

  // One clock: drive, check comb outputs mid-cycle, then check ID/EX after the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic rst);
    logic exp_stall;
    @(negedge clk);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc    = pc;
    bus.ex_flush = fl;
    reset        = rst;
    #1;
    exp_stall  = ref_hazard(ins, v) && !fl;
    stall_seen = bus.stall;
    chk("Rs1",   {27'd0, bus.Rs1}, {27'd0, ins[25:21]});
    chk("Rs2",   {27'd0, bus.Rs2}, {27'd0, ins[20:16]});
    chk("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
    @(posedge clk);
    #1;
    if (rst) begin
      m    = '0;
      m_pi = 32'd0;
      m_ps = 32'd0;
    end else begin
      if (exp_stall) m_ps = m_ps + 32'd1;
      if (fl || exp_stall) m = '0;
      else begin
        m = decode_ref(ins, pc, v);
        if (v) m_pi = m_pi + 32'd1;
      end
    end
    m_stall_last = exp_stall;
    chk("ex_valid",    {31'd0, bus.ex_valid},    {31'd0, m.valid});
    chk("ex_pc",       bus.ex_pc,                m.pc);
    chk("ex_op",       {26'd0, bus.ex_op},       {26'd0, m.op});
    chk("ex_func",     {26'd0, bus.ex_func},     {26'd0, m.func});
    chk("ex_rd",       {27'd0, bus.ex_rd},       {27'd0, m.rd});
    chk("ex_imm",      bus.ex_imm,               m.imm);
    chk("ex_is_load",  {31'd0, bus.ex_is_load},  {31'd0, m.ld});
    chk("ex_is_store", {31'd0, bus.ex_is_store}, {31'd0, m.st});
    chk("ex_reg_we",   {31'd0, bus.ex_reg_we},   {31'd0, m.we});
`ifdef DECODE_PERF_EN
    chk("perf_instr", perf_instr, m_pi);
    chk("perf_stall", perf_stall, m_ps);
`else
    chk("perf_instr", perf_instr, 32'd0);
    chk("perf_stall", perf_stall, 32'd0);
`endif
  endtask

  localparam logic [31:0] LW_R5   = 32'h8C25_0008; // LW  r5,8(r1)
  localparam logic [31:0] ADD_R6  = 32'h00A2_3020; // ADD r6,r5,r2
  localparam logic [31:0] SW_R5   = 32'hACE5_0000; // SW  r5,0(r7)
  localparam logic [31:0] LW_R0   = 32'h8C20_0008; // LW  r0,8(r1)
  localparam logic [31:0] ADD_R0S = 32'h0002_3020; // ADD r6,r0,r2

  vec_t tbl[14];
  logic [5:0] ops[22];

  initial begin
    tbl[0]  = '{32'h0022_1820, 32'h100, 5'd3,  6'h20, 32'h0000_1820, 1'b1, 1'b0, 1'b0}; // ADD r3,r1,r2
    tbl[1]  = '{32'h3404_FFFF, 32'h104, 5'd4,  6'h00, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0}; // ORI
    tbl[2]  = '{32'h2004_FFFF, 32'h108, 5'd4,  6'h00, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}; // ADDI
    tbl[3]  = '{32'h0FFF_FFFC, 32'h10C, 5'd31, 6'h00, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0}; // JAL -4
    tbl[4]  = '{LW_R5,         32'h110, 5'd5,  6'h00, 32'h0000_0008, 1'b1, 1'b1, 1'b0}; // LW
    tbl[5]  = '{SW_R5,         32'h114, 5'd0,  6'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b1}; // SW
    tbl[6]  = '{32'h3C02_1234, 32'h118, 5'd2,  6'h00, 32'h1234_0000, 1'b1, 1'b0, 1'b0}; // LHI
    tbl[7]  = '{32'h1020_FFF8, 32'h11C, 5'd0,  6'h00, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0}; // BEQZ
    tbl[8]  = '{32'h0800_0100, 32'h120, 5'd0,  6'h00, 32'h0000_0100, 1'b0, 1'b0, 1'b0}; // J
    tbl[9]  = '{32'h4BE0_0000, 32'h124, 5'd0,  6'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0}; // JR r31
    tbl[10] = '{32'h4C40_0000, 32'h128, 5'd31, 6'h00, 32'h0000_0000, 1'b1, 1'b0, 1'b0}; // JALR r2
    tbl[11] = '{32'h0022_0020, 32'h12C, 5'd0,  6'h20, 32'h0000_0020, 1'b0, 1'b0, 1'b0}; // ADD r0
    tbl[12] = '{32'h3029_8000, 32'h130, 5'd9,  6'h00, 32'h0000_8000, 1'b1, 1'b0, 1'b0}; // ANDI
    tbl[13] = '{32'h0A00_0000, 32'h134, 5'd0,  6'h00, 32'hFE00_0000, 1'b0, 1'b0, 1'b0}; // J neg
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h12, 6'h13, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h0A};

    m = '0; m_pi = 32'd0; m_ps = 32'd0; m_stall_last = 1'b0; stall_seen = 1'b0;
    reset = 1'b1;
    bus.if_valid = 1'b0; bus.if_instr = 32'd0; bus.if_pc = 32'd0; bus.ex_flush = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held two cycles
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("reset_stall", {31'd0, stall_seen}, 32'd0);

    // Field decode table, each entry isolated by an idle cycle
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      step(1'b1, tbl[i].instr, tbl[i].pc, 1'b0, 1'b0);
      chk("tbl_pc",    bus.ex_pc, tbl[i].pc);
      chk("tbl_rd",    {27'd0, bus.ex_rd}, {27'd0, tbl[i].rd});
      chk("tbl_func",  {26'd0, bus.ex_func}, {26'd0, tbl[i].func});
      chk("tbl_imm",   bus.ex_imm, tbl[i].imm);
      chk("tbl_we",    {31'd0, bus.ex_reg_we}, {31'd0, tbl[i].we});
      chk("tbl_load",  {31'd0, bus.ex_is_load}, {31'd0, tbl[i].ld});
      chk("tbl_store", {31'd0, bus.ex_is_store}, {31'd0, tbl[i].st});
    end

    // Load-use on rs1: one stall cycle, bubble, then the ADD issues
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(1'b1, LW_R5, 32'h200, 1'b0, 1'b0);
    step(1'b1, ADD_R6, 32'h204, 1'b0, 1'b0);
    chk("lu_stall", {31'd0, stall_seen}, 32'd1);
    chk("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
    step(1'b1, ADD_R6, 32'h204, 1'b0, 1'b0);
    chk("lu_release", {31'd0, stall_seen}, 32'd0);
    chk("lu_issue_rd", {27'd0, bus.ex_rd}, 32'd6);
`ifdef DECODE_PERF_EN
    chk("lu_perf_stall", perf_stall, 32'd1);
`else
    chk("lu_perf_stall", perf_stall, 32'd0);
`endif

    // Store data register counts as a used source; r0 never hazards
    step(1'b1, LW_R5, 32'h208, 1'b0, 1'b0);
    step(1'b1, SW_R5, 32'h20C, 1'b0, 1'b0);
    chk("sw_stall", {31'd0, stall_seen}, 32'd1);
    step(1'b1, SW_R5, 32'h20C, 1'b0, 1'b0);
    step(1'b1, LW_R0, 32'h210, 1'b0, 1'b0);
    step(1'b1, ADD_R0S, 32'h214, 1'b0, 1'b0);
    chk("r0_nostall", {31'd0, stall_seen}, 32'd0);

    // Flush wins over a load-use stall
    step(1'b1, LW_R5, 32'h218, 1'b0, 1'b0);
    step(1'b1, ADD_R6, 32'h21C, 1'b1, 1'b0);
    chk("fl_stall", {31'd0, stall_seen}, 32'd0);
    chk("fl_valid", {31'd0, bus.ex_valid}, 32'd0);

    // Reset during a stall drops the bubble; no stall afterwards
    step(1'b1, LW_R5, 32'h220, 1'b0, 1'b0);
    step(1'b1, ADD_R6, 32'h224, 1'b0, 1'b1);
    chk("rst_in_stall", {31'd0, stall_seen}, 32'd1);
    step(1'b1, ADD_R6, 32'h224, 1'b0, 1'b0);
    chk("rst_after", {31'd0, stall_seen}, 32'd0);
    chk("rst_issue", {31'd0, bus.ex_valid}, 32'd1);

    // Randomized traffic with small register numbers to provoke hazards
    begin
      logic [31:0] ins, pc, r;
      logic v;
      ins = 32'd0; pc = 32'h1000; v = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if (!m_stall_last) begin
          r   = $urandom();
          ins = {ops[$urandom_range(0, 21)], 3'b000, 2'(r[22:21]), 3'b000, 2'(r[17:16]),
                 3'b000, 2'(r[12:11]), r[10:0]};
          if (r[31:30] == 2'b11) ins = $urandom();
          pc  = pc + 32'd4;
          v   = ($urandom_range(0, 9) != 0);
        end
        step(v, ins, pc, ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
